// File: rtl/or1200_checker_resp.sv
// Checker response FSM: filters checker violations, raises an alarm handshake, then locks the CPU frozen.
// Optional violation logging is enabled with `define OR1200_CHECKER_RESP_LOG_EN.
module or1200_checker_resp #(
    parameter logic [3:0] filter_len = 4'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sr_ok,
    input  logic       pipeline_ok,
    input  logic       mmus_ok,
    input  logic [2:0] secure_supv,
    input  logic       sr_sm,
    input  logic       chk_en,
    input  logic       alarm_ack,
    input  logic       clr_req,
    output logic       alarm_req,
    output logic       cpu_freeze_req,
    output logic       locked,
    output logic [3:0] viol_vec,
    output logic [7:0] viol_cnt
);

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        SUSPECT = 2'd1,
        ALARM   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] fcnt_q, fcnt_d;
    logic       dec_supv;
    logic [3:0] v;
    logic       any_viol;

    assign dec_supv = ~^secure_supv;
    assign v        = {dec_supv != sr_sm, ~mmus_ok, ~pipeline_ok, ~sr_ok};
    assign any_viol = chk_en & (|v);

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            MONITOR: begin
                if (any_viol) begin
                    fcnt_d  = 4'd1;
                    state_d = (filter_len == 4'd1) ? ALARM : SUSPECT;
                end else begin
                    fcnt_d  = 4'd0;
                end
            end
            SUSPECT: begin
                if (!any_viol) begin
                    fcnt_d  = 4'd0;
                    state_d = MONITOR;
                end else if (4'(fcnt_q + 4'd1) == filter_len) begin
                    state_d = ALARM;
                end else begin
                    fcnt_d  = 4'(fcnt_q + 4'd1);
                end
            end
            // Ack is only meaningful once ALARM is the registered state.
            ALARM: begin
                if (alarm_ack) state_d = LOCKED;
            end
            LOCKED: begin
                if (clr_req && sr_sm) begin
                    fcnt_d  = 4'd0;
                    state_d = MONITOR;
                end
            end
            default: begin
                fcnt_d  = 4'd0;
                state_d = MONITOR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MONITOR;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign alarm_req      = (state_q == ALARM);
    assign cpu_freeze_req = (state_q == ALARM) || (state_q == LOCKED);
    assign locked         = (state_q == LOCKED);

`ifdef OR1200_CHECKER_RESP_LOG_EN
    logic       enter_alarm;
    logic [3:0] viol_vec_q, viol_vec_d;
    logic [7:0] viol_cnt_q, viol_cnt_d;

    assign enter_alarm = (state_d == ALARM) && (state_q != ALARM);

    always_comb begin
        viol_vec_d = viol_vec_q;
        viol_cnt_d = viol_cnt_q;
        if (enter_alarm) begin
            viol_vec_d = v;
            if (viol_cnt_q != 8'hFF) viol_cnt_d = viol_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            viol_vec_q <= 4'h0;
            viol_cnt_q <= 8'h00;
        end else begin
            viol_vec_q <= viol_vec_d;
            viol_cnt_q <= viol_cnt_d;
        end
    end

    assign viol_vec = viol_vec_q;
    assign viol_cnt = viol_cnt_q;
`else
    assign viol_vec = 4'h0;
    assign viol_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_or1200_checker_resp.sv
// Directed self-checking bench for or1200_checker_resp (default filter_len=2 plus a filter_len=1 instance).
module tb_or1200_checker_resp;

    logic       clk = 1'b0;
    logic       rst, sr_ok, pipeline_ok, mmus_ok, sr_sm, chk_en, alarm_ack, clr_req;
    logic [2:0] secure_supv;
    logic       alarm_req, cpu_freeze_req, locked;
    logic [3:0] viol_vec;
    logic [7:0] viol_cnt;
    logic       alarm_req1, cpu_freeze_req1, locked1;
    logic [3:0] viol_vec1;
    logic [7:0] viol_cnt1;

    int n_cmp = 0;
    int n_err = 0;

`ifdef OR1200_CHECKER_RESP_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    always #5 clk = ~clk;

    or1200_checker_resp dut (
        .clk(clk), .rst(rst), .sr_ok(sr_ok), .pipeline_ok(pipeline_ok), .mmus_ok(mmus_ok),
        .secure_supv(secure_supv), .sr_sm(sr_sm), .chk_en(chk_en), .alarm_ack(alarm_ack),
        .clr_req(clr_req), .alarm_req(alarm_req), .cpu_freeze_req(cpu_freeze_req),
        .locked(locked), .viol_vec(viol_vec), .viol_cnt(viol_cnt)
    );

    or1200_checker_resp #(.filter_len(4'd1)) dut1 (
        .clk(clk), .rst(rst), .sr_ok(sr_ok), .pipeline_ok(pipeline_ok), .mmus_ok(mmus_ok),
        .secure_supv(secure_supv), .sr_sm(sr_sm), .chk_en(chk_en), .alarm_ack(alarm_ack),
        .clr_req(clr_req), .alarm_req(alarm_req1), .cpu_freeze_req(cpu_freeze_req1),
        .locked(locked1), .viol_vec(viol_vec1), .viol_cnt(viol_cnt1)
    );

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic healthy();
        sr_ok = 1'b1; pipeline_ok = 1'b1; mmus_ok = 1'b1;
        secure_supv = 3'b000; sr_sm = 1'b1; chk_en = 1'b1;
        alarm_ack = 1'b0; clr_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic a, input logic f, input logic l);
        chk({tag, ".alarm"},  {7'd0, alarm_req}, {7'd0, a});
        chk({tag, ".freeze"}, {7'd0, cpu_freeze_req}, {7'd0, f});
        chk({tag, ".locked"}, {7'd0, locked}, {7'd0, l});
    endtask

    initial begin
        healthy();
        do_reset();
        chk_outs("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.vec", {4'd0, viol_vec}, 8'h00);
        chk("reset.cnt", viol_cnt, 8'h00);
        chk("reset1.alarm", {7'd0, alarm_req1}, 8'h00);

        // Single-cycle glitches never reach the alarm at filter_len=2.
        for (int i = 0; i < 2; i++) begin
            sr_ok = 1'b0; step(); chk("glitch.suspect", {7'd0, alarm_req}, 8'h00);
            sr_ok = 1'b1; step(); chk("glitch.monitor", {7'd0, alarm_req}, 8'h00);
        end
        step();
        chk_outs("glitch.end", 1'b0, 1'b0, 1'b0);
        chk("glitch.cnt", viol_cnt, 8'h00);

        // MMU violation for 2 cycles; ack held during the entry edge must be ignored.
        do_reset();
        mmus_ok = 1'b0; step();
        chk("mmu.c1", {7'd0, alarm_req}, 8'h00);
        alarm_ack = 1'b1; step();
        chk_outs("mmu.c2", 1'b1, 1'b1, 1'b0);
        chk("mmu.vec", {4'd0, viol_vec}, LOG ? 8'h04 : 8'h00);
        chk("mmu.cnt", viol_cnt, LOG ? 8'h01 : 8'h00);
        alarm_ack = 1'b0; mmus_ok = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk_outs("mmu.hold", 1'b1, 1'b1, 1'b0);

        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        chk_outs("ack.locked", 1'b0, 1'b1, 1'b1);
        clr_req = 1'b1; sr_sm = 1'b0; secure_supv = 3'b001; step();
        chk_outs("clr.user", 1'b0, 1'b1, 1'b1);
        sr_sm = 1'b1; secure_supv = 3'b000; step(); clr_req = 1'b0;
        chk_outs("clr.supv", 1'b0, 1'b0, 1'b0);
        chk("clr.vec_kept", {4'd0, viol_vec}, LOG ? 8'h04 : 8'h00);
        chk("clr.cnt_kept", viol_cnt, LOG ? 8'h01 : 8'h00);

        // Violation persisting across the clear is re-detected from the first MONITOR cycle.
        sr_ok = 1'b0; step(); step();
        chk("sr.alarm", {7'd0, alarm_req}, 8'h01);
        chk("sr.cnt", viol_cnt, LOG ? 8'h02 : 8'h00);
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        clr_req = 1'b1; step(); clr_req = 1'b0;
        chk_outs("redet.monitor", 1'b0, 1'b0, 1'b0);
        step(); chk("redet.suspect", {7'd0, alarm_req}, 8'h00);
        step(); chk("redet.alarm", {7'd0, alarm_req}, 8'h01);
        chk("redet.vec", {4'd0, viol_vec}, LOG ? 8'h01 : 8'h00);
        chk("redet.cnt", viol_cnt, LOG ? 8'h03 : 8'h00);

        // Reset mid-SUSPECT (with violation present) and in LOCKED.
        do_reset(); healthy();
        sr_ok = 1'b0; step();
        rst = 1'b1; clr_req = 1'b1; step(); rst = 1'b0; clr_req = 1'b0;
        chk_outs("rst.suspect", 1'b0, 1'b0, 1'b0);
        chk("rst.suspect.cnt", viol_cnt, 8'h00);
        step(); step(); alarm_ack = 1'b1; step();
        chk_outs("pre.rstlock", 1'b0, 1'b1, 1'b1);
        rst = 1'b1; step(); rst = 1'b0; alarm_ack = 1'b0;
        chk_outs("rst.locked", 1'b0, 1'b0, 1'b0);
        chk("rst.locked.vec", {4'd0, viol_vec}, 8'h00);
        chk("rst.locked.cnt", viol_cnt, 8'h00);

        // chk_en=0 masks everything in MONITOR, but not an established ALARM.
        healthy();
        chk_en = 1'b0; sr_ok = 1'b0; pipeline_ok = 1'b0; mmus_ok = 1'b0; secure_supv = 3'b001;
        for (int i = 0; i < 4; i++) step();
        chk_outs("mask.monitor", 1'b0, 1'b0, 1'b0);
        chk("mask1.alarm", {7'd0, alarm_req1}, 8'h00);
        chk_en = 1'b1; step(); step();
        chk("unmask.alarm", {7'd0, alarm_req}, 8'h01);
        chk("unmask.vec", {4'd0, viol_vec}, LOG ? 8'h0F : 8'h00);
        chk_en = 1'b0; step();
        chk_outs("mask.alarm", 1'b1, 1'b1, 1'b0);

        // User-mode parity with SR[SM]=1, filter_len=1 alarms on the next cycle.
        healthy(); do_reset();
        secure_supv = 3'b001; step();
        chk("user.alarm1", {7'd0, alarm_req1}, 8'h01);
        chk("user.vec1", {4'd0, viol_vec1}, LOG ? 8'h08 : 8'h00);
        chk("user.alarm2", {7'd0, alarm_req}, 8'h00);
        secure_supv = 3'b011; step();
        chk("par.even", {7'd0, alarm_req}, 8'h00);

        // 256 alarm/ack/clear rounds: the log counter saturates.
        healthy(); do_reset();
        for (int i = 0; i < 256; i++) begin
            sr_ok = 1'b0; step(); step();
            if (i == 9) chk("sat.cnt10", viol_cnt, LOG ? 8'd10 : 8'd0);
            sr_ok = 1'b1; alarm_ack = 1'b1; step();
            alarm_ack = 1'b0; clr_req = 1'b1; step(); clr_req = 1'b0;
        end
        chk("sat.cnt", viol_cnt, LOG ? 8'hFF : 8'h00);
        chk_outs("sat.end", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/or1200_checker_resp.md
OR1200_CHECKER_RESP -- requirements
Module: or1200_checker_resp

Interface
REQ-001 The block SHALL have a parameter filter_len, default 4'd2, giving the consecutive violation cycles needed to raise an alarm (legal range 1..15).
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-003 The block SHALL have these ports:
- clk  input  1  CPU clock.
- rst  input  1  Synchronous active-high reset.
- sr_ok  input  1  Checker SR-consistency flag; 1 = healthy.
- pipeline_ok  input  1  Checker pipeline flag; 1 = healthy.
- mmus_ok  input  1  Checker MMU-enable flag; 1 = healthy.
- secure_supv  input  3  Parity-encoded supervisor state; even parity = supervisor, odd parity = user.
- sr_sm  input  1  Live SR[SM] bit from the SPR file.
- chk_en  input  1  Detection enable; 0 masks new violations.
- alarm_ack  input  1  Acknowledge from the exception/trap logic.
- clr_req  input  1  Request to leave the lock state.
- alarm_req  output  1  Alarm handshake request.
- cpu_freeze_req  output  1  Request to hold the CPU pipeline frozen.
- locked  output  1  The block is in the LOCKED state.
- viol_vec  output  4  Captured violation cause.
- viol_cnt  output  8  Count of alarms raised.

Function
REQ-004 The block SHALL decode the supervisor state combinationally as dec_supv = ~^secure_supv.
REQ-005 The block SHALL form the violation vector v = {dec_supv != sr_sm, ~mmus_ok, ~pipeline_ok, ~sr_ok}.
REQ-006 The block SHALL compute any_viol = chk_en & |v.
REQ-007 The block SHALL implement a four-state FSM with states MONITOR, SUSPECT, ALARM and LOCKED, plus a 4-bit filter counter fcnt.
REQ-008 In MONITOR, when any_viol=1, the FSM SHALL set fcnt=1 and move to ALARM if filter_len==1, otherwise to SUSPECT; when any_viol=0 it SHALL stay in MONITOR with fcnt=0.
REQ-009 In SUSPECT, the FSM SHALL behave as follows:
- any_viol=1 and fcnt+1==filter_len: move to ALARM.
- any_viol=1 otherwise: increment fcnt and stay in SUSPECT.
- any_viol=0: return to MONITOR and set fcnt=0.
REQ-010 In ALARM, alarm_req=1 and cpu_freeze_req=1; alarm_ack=1 SHALL move the FSM to LOCKED.
REQ-011 alarm_ack SHALL be sampled only in ALARM; it is ignored in every other state, including the cycle of ALARM entry.
REQ-012 In LOCKED, cpu_freeze_req=1, locked=1 and alarm_req=0.
REQ-013 In LOCKED, clr_req=1 together with sr_sm=1 SHALL move the FSM to MONITOR with fcnt=0; clr_req while sr_sm=0 SHALL be ignored.
REQ-014 All outputs SHALL be registered or decoded from registered state only.
REQ-015 Alarm latency: a violation that first appears at cycle 0 and persists SHALL produce alarm_req=1 in cycle filter_len.
REQ-016 chk_en=0 SHALL NOT affect the ALARM or LOCKED states; in MONITOR and SUSPECT it forces any_viol=0.
REQ-017 After a clr_req exit with a violation still present, the violation SHALL be re-detected starting in the first MONITOR cycle.
REQ-018 alarm_req SHALL remain high until acknowledged; no timeout applies.

Reset
REQ-019 When rst=1 at a clock edge, the block SHALL return to MONITOR from any state, including mid-SUSPECT and mid-handshake.
REQ-020 Reset SHALL set fcnt=0, alarm_req=0, cpu_freeze_req=0, locked=0, viol_vec=4'h0 and viol_cnt=8'h00.
REQ-021 rst SHALL take priority over every other input.

Configuration
REQ-022 The macro OR1200_CHECKER_RESP_LOG_EN SHALL control the logging feature.
REQ-023 With OR1200_CHECKER_RESP_LOG_EN defined, the block SHALL behave as follows:
- On each transition into ALARM, latch viol_vec = v from the triggering cycle.
- On each transition into ALARM, increment viol_cnt, saturating at 8'hFF.
- Neither viol_vec nor viol_cnt is cleared by clr_req.
REQ-024 Without OR1200_CHECKER_RESP_LOG_EN, viol_vec SHALL be tied to 4'h0 and viol_cnt to 8'h00, with no log registers synthesized; the FSM behaviour SHALL be unchanged.

Verification
REQ-025 Scenario, default parameter: pulse sr_ok=0 for 1 cycle -> SUSPECT then MONITOR; alarm_req never asserts; viol_cnt=0.
REQ-026 Scenario, default parameter, LOG_EN defined: mmus_ok=0 for 2 cycles -> alarm_req=1 in cycle 2, cpu_freeze_req=1, viol_vec=4'b0100, viol_cnt=1.
REQ-027 Scenario: secure_supv=3'b001 (user) with sr_sm=1 and filter_len=1 -> alarm_req=1 next cycle; with LOG_EN defined, viol_vec=4'b1000.
REQ-028 Scenario: in ALARM, pulse alarm_ack -> locked=1 and alarm_req=0 next cycle; clr_req with sr_sm=0 -> stays LOCKED; clr_req with sr_sm=1 -> MONITOR and cpu_freeze_req=0.
REQ-029 Scenario: rst=1 asserted mid-SUSPECT and again in LOCKED -> all outputs 0 on the next cycle; chk_en=0 with all flags bad -> remains in MONITOR.
REQ-030 Scenario, LOG_EN defined: force 256 alarm/ack/clear cycles -> viol_cnt saturates at 8'hFF; without LOG_EN, viol_cnt stays 8'h00 throughout.
